hex_dec_formatter: RTL and testbench

HEX_DEC_FORMATTER -- requirements
Module: hex_dec_formatter

---
 rtl/hex_dec_formatter_if.sv | 23 ++
 rtl/hex_dec_formatter.sv | 140 ++++++++++++++
 tb/tb_hex_dec_formatter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hex_dec_formatter_if.sv
// Request/result bundle between a requester and the hex/decimal digit formatter.
// master: requester side; slave: formatter side.
interface hex_dec_formatter_if;
  logic        start;
  logic        mode;
  logic [15:0] value;
  logic [15:0] digits;
  logic [1:0]  ones_place;
  logic        dp_en;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output start, mode, value,
    input  digits, ones_place, dp_en, busy, done, overflow
  );

  modport slave (
    input  start, mode, value,
    output digits, ones_place, dp_en, busy, done, overflow
  );
endinterface

// File: rtl/hex_dec_formatter.sv
// Formats a 16-bit value into four display digits, either as a hex passthrough or as
// decimal BCD via a 16-step iterative double-dabble.
// Optional build macro HEX_DEC_SIGNED_EN: decimal mode treats value as two's complement,
// converts the magnitude and flags negatives with ones_place=3.
module hex_dec_formatter #(
  parameter logic [15:0] OVF_DIGITS = 16'h9999
) (
  input logic             clk,
  input logic             rst,
  hex_dec_formatter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [15:0] digits_q, digits_d;
  logic [1:0]  ones_q, ones_d;
  logic        dp_q, dp_d;
  logic        ovf_q, ovf_d;

  logic        is_neg;
  logic [15:0] operand;
  logic [19:0] acc_adj;
  logic [19:0] acc_shift;

`ifdef HEX_DEC_SIGNED_EN
  // 16'h8000 negates to itself, i.e. 32768 unsigned, which then overflows.
  assign is_neg  = bus.value[15];
  assign operand = is_neg ? (~bus.value + 16'd1) : bus.value;
`else
  assign is_neg  = 1'b0;
  assign operand = bus.value;
`endif

  // One double-dabble step: add 3 to BCD digits >= 5, then shift in the next operand MSB.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[18:0], shreg_q[15]};
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    digits_d = digits_q;
    ones_d   = ones_q;
    dp_d     = dp_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d = '0;
          cnt_d = '0;
          if (bus.mode) begin
            shreg_d = operand;
            neg_d   = is_neg;
            state_d = StConvert;
          end else begin
            // Hex results are final at the accepting edge.
            shreg_d  = '0;
            neg_d    = 1'b0;
            digits_d = bus.value;
            ones_d   = 2'd0;
            dp_d     = 1'b0;
            ovf_d    = 1'b0;
            state_d  = StDone;
          end
        end
      end
      StConvert: begin
        acc_d   = acc_shift;
        shreg_d = {shreg_q[14:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          if (acc_shift[19:16] == 4'd0) begin
            digits_d = acc_shift[15:0];
            ovf_d    = 1'b0;
          end else begin
            digits_d = OVF_DIGITS;
            ovf_d    = 1'b1;
          end
          dp_d    = 1'b1;
          ones_d  = neg_q ? 2'd3 : 2'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; reset discards any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      digits_q <= '0;
      ones_q   <= 2'd0;
      dp_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      digits_q <= digits_d;
      ones_q   <= ones_d;
      dp_q     <= dp_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.ones_place = ones_q;
  assign bus.dp_en      = dp_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_hex_dec_formatter.sv
// Directed bench for hex_dec_formatter with a scoreboard of expected results.
module tb_hex_dec_formatter;

  localparam logic [15:0] OvfDigits = 16'h9999;

  typedef struct {
    logic [15:0] digits;
    logic [1:0]  ones;
    logic        dp;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t last_exp;

  hex_dec_formatter_if bus_if ();

  hex_dec_formatter #(.OVF_DIGITS(OvfDigits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: arithmetic digit extraction rather than double-dabble.
  function automatic exp_t model(input bit m, input logic [15:0] v);
    exp_t e;
    int   mag;
    bit   neg;
    if (!m) begin
      e.digits = v;
      e.ones   = 2'd0;
      e.dp     = 1'b0;
      e.ovf    = 1'b0;
      e.lat    = 1;
    end else begin
      mag = int'(v);
      neg = 1'b0;
`ifdef HEX_DEC_SIGNED_EN
      if (v[15]) begin
        mag = 65536 - int'(v);
        neg = 1'b1;
      end
`endif
      if (mag > 9999) begin
        e.digits = OvfDigits;
        e.ovf    = 1'b1;
      end else begin
        e.digits = {4'((mag / 1000) % 10), 4'((mag / 100) % 10),
                    4'((mag / 10) % 10), 4'(mag % 10)};
        e.ovf    = 1'b0;
      end
      e.dp   = 1'b1;
      e.ones = neg ? 2'd3 : 2'd0;
      e.lat  = 17;
    end
    return e;
  endfunction

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".digits"}, 32'(bus_if.digits), 32'(e.digits));
    chk({tag, ".ones"}, 32'(bus_if.ones_place), 32'(e.ones));
    chk({tag, ".dp"}, 32'(bus_if.dp_en), 32'(e.dp));
    chk({tag, ".ovf"}, 32'(bus_if.overflow), 32'(e.ovf));
  endtask

  // Issue one request; inputs are scrambled after acceptance, optionally with start held.
  task automatic run_op(input bit m, input logic [15:0] v, input bit hold, input bit rel_rst);
    exp_t e;
    exp_t got;
    int   ndone;
    e = model(m, v);
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.mode  = m;
    bus_if.value = v;
    if (rel_rst) rst = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", n), 32'(bus_if.busy), 32'(n <= e.lat));
      chk($sformatf("done_c%0d", n), 32'(bus_if.done), 32'(n == e.lat));
      if (n == 5 && e.lat > 5) chk_outputs("hold_while_busy", last_exp);
      if (bus_if.done === 1'b1) begin
        ndone++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk_outputs($sformatf("result_%0h", v), got);
          last_exp = got;
        end
      end
      if (n == 1) begin
        bus_if.mode  = ~m;
        bus_if.value = hold ? 16'd5678 : ~v;
        bus_if.start = hold;
      end
      if (n == 17) bus_if.start = 1'b0;
    end
    chk("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.mode  = 1'b0;
    bus_if.value = 16'h0;
    last_exp = '{digits: 16'h0, ones: 2'd0, dp: 1'b0, ovf: 1'b0, lat: 0};

    repeat (2) @(negedge clk);
    chk_outputs("reset", last_exp);
    chk("reset.busy", 32'(bus_if.busy), 32'd0);
    chk("reset.done", 32'(bus_if.done), 32'd0);

    // Start accepted on the first edge after reset release.
    run_op(1'b1, 16'd1234, 1'b0, 1'b1);
    run_op(1'b1, 16'd9999, 1'b0, 1'b0);
    run_op(1'b1, 16'd10000, 1'b0, 1'b0);
    run_op(1'b0, 16'hBEEF, 1'b0, 1'b0);
    run_op(1'b1, 16'd0, 1'b0, 1'b0);
    run_op(1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 1'b0, 1'b0);
    run_op(1'b1, 16'd305, 1'b0, 1'b0);
    run_op(1'b0, 16'h00A5, 1'b0, 1'b0);
    // Second start held high while busy must be ignored.
    run_op(1'b1, 16'd1234, 1'b1, 1'b0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.mode  = 1'b1;
    bus_if.value = 16'd1234;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) bus_if.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    last_exp = '{digits: 16'h0, ones: 2'd0, dp: 1'b0, ovf: 1'b0, lat: 0};
    chk_outputs("mid_reset", last_exp);
    chk("mid_reset.busy", 32'(bus_if.busy), 32'd0);
    chk("mid_reset.done", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      chk($sformatf("no_done_after_reset_c%0d", n), 32'(bus_if.done), 32'd0);
    end
    run_op(1'b1, 16'd42, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
